// File: rtl/pe_ctrl_if.sv
// Bus bundle between pe_ctrl and its environment: the input word stream,
// the PE local-RAM / operand / result port and the job-result stream.
//   master : controller side (pe_ctrl)
//   slave  : environment side (stream source, PE, result sink)
interface pe_ctrl_if #(
    parameter int unsigned L_RAM_SIZE = 3
);
    localparam int unsigned DW = 32;

    logic [DW-1:0]         s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;

    logic [DW-1:0]         pe_din;
    logic [L_RAM_SIZE-1:0] pe_addr;
    logic                  pe_we;
    logic [DW-1:0]         pe_ain;
    logic                  pe_valid;
    logic [DW-1:0]         pe_dout;
    logic                  pe_dvalid;

    logic [DW-1:0]         m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;

    modport master (
        input  s_tdata, s_tvalid, pe_dout, pe_dvalid, m_tready,
        output s_tready, pe_din, pe_addr, pe_we, pe_ain, pe_valid, m_tdata, m_tvalid
    );

    modport slave (
        output s_tdata, s_tvalid, pe_dout, pe_dvalid, m_tready,
        input  s_tready, pe_din, pe_addr, pe_we, pe_ain, pe_valid, m_tdata, m_tvalid
    );
endinterface

// File: rtl/pe_ctrl.sv
// pe_ctrl: sequences one load/compute job for a MAC processing element.
// A job streams N words into the PE local RAM, buffers N operand words,
// replays them to the PE in lock-step with RAM reads, counts N result
// pulses and presents the last result on the output stream.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   start         : one-cycle job request (honoured only when idle)
//   busy          : high whenever a job is in progress
//   bus           : pe_ctrl_if master (s_* input stream, pe_* PE port, m_* result)
module pe_ctrl #(
    parameter int unsigned L_RAM_SIZE = 3
) (
    input  logic      aclk,
    input  logic      aresetn,
    input  logic      start,
    output logic      busy,
    pe_ctrl_if.master bus
);
    localparam int unsigned N  = 2 ** L_RAM_SIZE;
    localparam int unsigned CW = L_RAM_SIZE + 1;
    localparam int unsigned DW = 32;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] FULL = CW'(N);

    typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_A, RUN, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         dcnt_q, dcnt_d;
    logic [DW-1:0]         pe_din_q, pe_din_d;
    logic [L_RAM_SIZE-1:0] pe_addr_q, pe_addr_d;
    logic                  pe_we_q, pe_we_d;
    logic [DW-1:0]         pe_ain_q, pe_ain_d;
    logic                  pe_valid_q, pe_valid_d;
    logic [DW-1:0]         m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q;
    logic                  s_tready_q;
    logic                  busy_q;
    logic [DW-1:0]         abuf_q [N];
    logic                  abuf_we;
    logic                  accept;

    assign accept = bus.s_tvalid & s_tready_q;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters and next output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        pe_din_d   = pe_din_q;
        pe_addr_d  = pe_addr_q;
        pe_we_d    = 1'b0;
        pe_ain_d   = '0;
        pe_valid_d = 1'b0;
        m_tdata_d  = m_tdata_q;
        abuf_we    = 1'b0;

        // Result pulses count only while operands are in flight; the N-th is the answer.
        if ((state_q == RUN || state_q == WAIT) && bus.pe_dvalid && (dcnt_q != FULL)) begin
            dcnt_d = dcnt_q + ONE;
            if (dcnt_q == LAST) begin
                m_tdata_d = bus.pe_dout;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_B;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                end
            end
            LOAD_B: begin
                if (accept) begin
                    pe_din_d  = bus.s_tdata;
                    pe_addr_d = cnt_q[L_RAM_SIZE-1:0];
                    pe_we_d   = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            LOAD_A: begin
                if (accept) begin
                    abuf_we = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d   = RUN;
                        cnt_d     = '0;
                        pe_addr_d = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            RUN: begin
                // Cycle r presents address r; operand r follows one cycle later.
                if (cnt_q != FULL) begin
                    pe_valid_d = 1'b1;
                    pe_ain_d   = abuf_q[cnt_q[L_RAM_SIZE-1:0]];
                    cnt_d      = cnt_q + ONE;
                    if (cnt_q != LAST) begin
                        pe_addr_d = L_RAM_SIZE'(cnt_q + ONE);
                    end
                end else begin
                    state_d = (dcnt_d == FULL) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dcnt_d == FULL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.m_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q      <= '0;
            dcnt_q     <= '0;
            pe_din_q   <= '0;
            pe_addr_q  <= '0;
            pe_we_q    <= 1'b0;
            pe_ain_q   <= '0;
            pe_valid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                abuf_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            pe_din_q   <= pe_din_d;
            pe_addr_q  <= pe_addr_d;
            pe_we_q    <= pe_we_d;
            pe_ain_q   <= pe_ain_d;
            pe_valid_q <= pe_valid_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= (state_d == DONE);
            s_tready_q <= (state_d == LOAD_B) || (state_d == LOAD_A);
            busy_q     <= (state_d != IDLE);
            if (abuf_we) begin
                abuf_q[cnt_q[L_RAM_SIZE-1:0]] <= bus.s_tdata;
            end
        end
    end

    assign bus.s_tready = s_tready_q;
    assign bus.pe_din   = pe_din_q;
    assign bus.pe_addr  = pe_addr_q;
    assign bus.pe_we    = pe_we_q;
    assign bus.pe_ain   = pe_ain_q;
    assign bus.pe_valid = pe_valid_q;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tvalid = m_tvalid_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_pe_ctrl.sv
// Self-checking bench for pe_ctrl (N = 8). A behavioural PE (local RAM with
// one-cycle read, running dot-product, configurable result latency) sits on
// the PE port; expected results are plain dot products of the job's words.
module tb_pe_ctrl;
    localparam int L = 3;
    localparam int N = 2 ** L;

    logic aclk, aresetn, start, busy;
    pe_ctrl_if #(.L_RAM_SIZE(L)) bus ();

    pe_ctrl #(.L_RAM_SIZE(L)) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .start  (start),
        .busy   (busy),
        .bus    (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] bw [N];
    logic [31:0] aw [N];

    bit          loading  = 1'b0;
    bit          pe_auto  = 1'b0;
    int          lat      = 2;
    bit          man_dv   = 1'b0;
    logic [31:0] man_dout = '0;

    logic [L+31:0] wr_q  [$];
    logic [31:0]   ain_q [$];
    int vruns = 0, bad_ain = 0, bad_tready = 0;
    bit prev_v = 1'b0;

    logic [31:0] ram [N] = '{default: '0};
    logic [31:0] rd_prev = '0;
    logic [31:0] acc = '0;
    bit          dv_pipe [4] = '{default: 1'b0};
    logic [31:0] do_pipe [4] = '{default: '0};

    // Observer plus behavioural PE, both working on the falling edge.
    always @(negedge aclk) begin
        logic        nv;
        logic [31:0] nval;
        if (start && !busy) begin
            wr_q.delete();
            ain_q.delete();
            vruns = 0; bad_ain = 0; bad_tready = 0; acc = '0;
        end
        if (bus.pe_we) wr_q.push_back({bus.pe_addr, bus.pe_din});
        if (bus.pe_valid) begin
            ain_q.push_back(bus.pe_ain);
            if (!prev_v) vruns++;
        end else if (bus.pe_ain !== 32'h0) begin
            bad_ain++;
        end
        if (bus.s_tready && !loading) bad_tready++;
        prev_v = bus.pe_valid;

        nv = 1'b0;
        nval = '0;
        if (pe_auto && bus.pe_valid) begin
            acc = acc + rd_prev * bus.pe_ain;
            nv = 1'b1;
            nval = acc;
        end
        rd_prev = ram[bus.pe_addr];
        if (bus.pe_we) ram[bus.pe_addr] = bus.pe_din;
        for (int i = 3; i > 0; i--) begin
            dv_pipe[i] = dv_pipe[i-1];
            do_pipe[i] = do_pipe[i-1];
        end
        dv_pipe[0] = nv;
        do_pipe[0] = nval;
        bus.pe_dvalid = dv_pipe[lat] | man_dv;
        bus.pe_dout   = man_dv ? man_dout : do_pipe[lat];
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] dot();
        logic [31:0] s = '0;
        for (int i = 0; i < N; i++) s = s + bw[i] * aw[i];
        return s;
    endfunction

    task automatic fixed_words();
        for (int i = 0; i < N; i++) begin
            bw[i] = 32'(i + 1);
            aw[i] = 32'(i + 10);
        end
    endtask

    task automatic random_words();
        for (int i = 0; i < N; i++) begin
            bw[i] = $urandom;
            aw[i] = $urandom;
        end
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
        loading = 1'b1;
    endtask

    // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
    task automatic stream(input int mode, input int start_at, output bit ok);
        int idx = 0;
        int n = 0;
        bit v;
        bit fired = 1'b0;
        while (idx < 2 * N && n < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_tvalid = v;
            bus.s_tdata  = v ? ((idx < N) ? bw[idx] : aw[idx - N]) : $urandom;
            start = (start_at >= 0) && (idx == start_at) && !fired;
            if (start) fired = 1'b1;
            if (v && bus.s_tready) idx++;
            tick();
            n++;
        end
        bus.s_tvalid = 1'b0;
        start = 1'b0;
        loading = 1'b0;
        ok = (idx == 2 * N);
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (bus.m_tvalid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        ok = (bus.m_tvalid === 1'b1);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        start = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata = '0;
        bus.m_tready = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.s_tready, bus.pe_we, bus.pe_valid, bus.m_tvalid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {bus.s_tready, bus.pe_we, bus.pe_valid, bus.m_tvalid, busy});
        end
        checks++;
        if ({bus.pe_din, bus.pe_ain, bus.m_tdata, bus.pe_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data din=%h ain=%h tdata=%h addr=%h want 0", bus.pe_din, bus.pe_ain, bus.m_tdata, bus.pe_addr);
        end
        aresetn = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || bus.s_tready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start busy=%b s_tready=%b want 0 0", busy, bus.s_tready);
        end
    endtask

    task automatic test_load_patterns();
        bit ok;
        logic [31:0] exp;
        int mode;
        bus.m_tready = 1'b1;
        for (int job = 0; job < 4; job++) begin
            mode = (job < 3) ? job : 2;
            if (job < 2) fixed_words(); else random_words();
            pe_auto = 1'b1;
            lat = (job < 2) ? 2 : int'($urandom_range(1, 3));
            exp = dot();
            start_job();
            stream(mode, -1, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL load_timeout job=%0d got incomplete want %0d words", job, 2 * N); end
            wait_valid(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL result_timeout job=%0d m_tvalid=%b want 1", job, bus.m_tvalid); end
            checks++;
            if (bus.m_tdata !== exp) begin errors++; $display("FAIL result job=%0d got %h want %h", job, bus.m_tdata, exp); end
            checks++;
            if (wr_q.size() != N || ain_q.size() != N || vruns != 1) begin
                errors++;
                $display("FAIL counts job=%0d writes=%0d ain=%0d runs=%0d want %0d %0d 1", job, wr_q.size(), ain_q.size(), vruns, N, N);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (i >= wr_q.size() || wr_q[i] !== {L'(i), bw[i]}) begin
                    errors++;
                    $display("FAIL write job=%0d k=%0d got %h want %h", job, i, (i < wr_q.size()) ? wr_q[i] : '0, {L'(i), bw[i]});
                end
                checks++;
                if (i >= ain_q.size() || ain_q[i] !== aw[i]) begin
                    errors++;
                    $display("FAIL ain job=%0d r=%0d got %h want %h", job, i, (i < ain_q.size()) ? ain_q[i] : '0, aw[i]);
                end
            end
            checks++;
            if (bad_ain != 0 || bad_tready != 0) begin
                errors++;
                $display("FAIL idle_outputs job=%0d ain_nonzero=%0d tready_outside=%0d want 0 0", job, bad_ain, bad_tready);
            end
            tick();
            checks++;
            if (bus.m_tvalid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL handshake job=%0d m_tvalid=%b busy=%b want 0 0", job, bus.m_tvalid, busy);
            end
        end
        bus.m_tready = 1'b0;
    endtask

    task automatic test_result_hold();
        bit ok;
        fixed_words();
        pe_auto = 1'b0;
        bus.m_tready = 1'b0;
        start_job();
        stream(0, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_load got incomplete want %0d words", 2 * N); end
        repeat (N + 3) tick();
        checks++;
        if (bus.m_tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_wait m_tvalid=%b busy=%b want 0 1", bus.m_tvalid, busy);
        end
        for (int p = 0; p < N; p++) begin
            man_dv = 1'b1;
            man_dout = (p == N - 1) ? 32'h0000_0474 : $urandom;
            tick();
            man_dv = 1'b0;
            if (p == N - 2) begin
                checks++;
                if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL hold_early m_tvalid=%b want 0", bus.m_tvalid); end
            end
        end
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'h474) begin
            errors++;
            $display("FAIL hold_result m_tvalid=%b tdata=%h want 1 00000474", bus.m_tvalid, bus.m_tdata);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'h474) begin
                errors++;
                $display("FAIL hold_stable c=%0d m_tvalid=%b tdata=%h want 1 00000474", c, bus.m_tvalid, bus.m_tdata);
            end
        end
        bus.m_tready = 1'b1;
        tick();
        bus.m_tready = 1'b0;
        checks++;
        if (bus.m_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release m_tvalid=%b busy=%b want 0 0", bus.m_tvalid, busy);
        end
    endtask

    task automatic test_ignore();
        bit ok;
        logic [31:0] exp;
        random_words();
        pe_auto = 1'b1;
        lat = 1;
        bus.m_tready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            man_dv = 1'b1;
            man_dout = $urandom;
            tick();
            man_dv = 1'b0;
            tick();
        end
        checks++;
        if (busy !== 1'b0 || bus.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_stray busy=%b m_tvalid=%b want 0 0", busy, bus.m_tvalid);
        end
        exp = dot();
        start_job();
        stream(1, N + 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ignore_load got incomplete want %0d words", 2 * N); end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || bus.m_tdata !== exp) begin
            errors++;
            $display("FAIL ignore_result got %h valid=%b want %h", bus.m_tdata, bus.m_tvalid, exp);
        end
        checks++;
        if (wr_q.size() != N || ain_q.size() != N || vruns != 1) begin
            errors++;
            $display("FAIL ignore_counts writes=%0d ain=%0d runs=%0d want %0d %0d 1", wr_q.size(), ain_q.size(), vruns, N, N);
        end
        bus.m_tready = 1'b1;
        tick();
        bus.m_tready = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || wr_q.size() != N) begin
            errors++;
            $display("FAIL ignore_restart busy=%b writes=%0d want 0 %0d", busy, wr_q.size(), N);
        end
    endtask

    task automatic test_reset_run();
        bit ok;
        logic [31:0] exp;
        random_words();
        pe_auto = 1'b1;
        lat = 2;
        bus.m_tready = 1'b0;
        start_job();
        stream(0, -1, ok);
        tick();
        tick();
        aresetn = 1'b0;
        #1;
        checks++;
        if ({bus.s_tready, bus.pe_we, bus.pe_valid, bus.m_tvalid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL run_reset_ctrl got %b want 00000", {bus.s_tready, bus.pe_we, bus.pe_valid, bus.m_tvalid, busy});
        end
        checks++;
        if ({bus.pe_din, bus.pe_ain, bus.m_tdata, bus.pe_addr} !== '0) begin
            errors++;
            $display("FAIL run_reset_data din=%h ain=%h tdata=%h addr=%h want 0", bus.pe_din, bus.pe_ain, bus.m_tdata, bus.pe_addr);
        end
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (4) tick();
        random_words();
        exp = dot();
        start_job();
        stream(2, -1, ok);
        wait_valid(ok);
        checks++;
        if (!ok || bus.m_tdata !== exp) begin
            errors++;
            $display("FAIL after_reset_result got %h valid=%b want %h", bus.m_tdata, bus.m_tvalid, exp);
        end
        checks++;
        if (wr_q.size() != N || ain_q.size() != N) begin
            errors++;
            $display("FAIL after_reset_counts writes=%0d ain=%0d want %0d %0d", wr_q.size(), ain_q.size(), N, N);
        end
        bus.m_tready = 1'b1;
        tick();
        bus.m_tready = 1'b0;
    endtask

    task automatic test_late_pulse();
        bit ok;
        logic [31:0] exp;
        random_words();
        pe_auto = 1'b1;
        lat = 0;
        bus.m_tready = 1'b0;
        exp = dot();
        start_job();
        stream(0, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL late_load got incomplete want %0d words", 2 * N); end
        repeat (N) tick();
        checks++;
        if (bus.m_tvalid !== 1'b0 || bus.pe_valid !== 1'b1) begin
            errors++;
            $display("FAIL late_lastrun m_tvalid=%b pe_valid=%b want 0 1", bus.m_tvalid, bus.pe_valid);
        end
        tick();
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== exp) begin
            errors++;
            $display("FAIL late_done m_tvalid=%b tdata=%h want 1 %h", bus.m_tvalid, bus.m_tdata, exp);
        end
        man_dv = 1'b1;
        man_dout = ~exp;
        tick();
        man_dv = 1'b0;
        tick();
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== exp) begin
            errors++;
            $display("FAIL late_extra m_tvalid=%b tdata=%h want 1 %h", bus.m_tvalid, bus.m_tdata, exp);
        end
        bus.m_tready = 1'b1;
        tick();
        bus.m_tready = 1'b0;
        checks++;
        if (bus.m_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL late_release m_tvalid=%b busy=%b want 0 0", bus.m_tvalid, busy);
        end
        lat = 2;
    endtask

    initial begin
        test_reset();
        test_load_patterns();
        test_result_hold();
        test_ignore();
        test_reset_run();
        test_late_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
